// File: rtl/nanorv32_trace_pkg.sv
// rtl/nanorv32_trace_pkg.sv - shared constants for the trace capture buffer
package nanorv32_trace_pkg;

  localparam int TRACE_W = 36;

  // Register word index, taken from wb_adr_i[3:2]
  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_CTRL   = 2'd1,
    REG_HEAD   = 2'd2,
    REG_DATA   = 2'd3
  } reg_idx_e;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_ENABLE    = 3;
  localparam int ST_LEVEL_LSB = 16;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  typedef enum logic [3:0] {
    FLAG_BRANCH = 4'b0001,
    FLAG_ADDR   = 4'b0010,
    FLAG_IRQ    = 4'b1000
  } trace_flag_e;

endpackage

// File: rtl/nanorv32_trace_wb_if.sv
// rtl/nanorv32_trace_wb_if.sv - classic Wishbone slave bundle for the trace buffer
interface nanorv32_trace_wb_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/nanorv32_sync_fifo.sv
// rtl/nanorv32_sync_fifo.sv - single-clock FIFO with level output and synchronous flush
module nanorv32_sync_fifo #(
  parameter int WIDTH      = 36,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);
  localparam int PW = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB tells a full ring from an empty one
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[PW-2:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[PW-2:0]] <= din;
  end

endmodule

// File: rtl/nanorv32_trace_wb.sv
// rtl/nanorv32_trace_wb.sv - Wishbone-readable capture buffer for the 36-bit trace stream
module nanorv32_trace_wb
  import nanorv32_trace_pkg::*;
#(
  parameter int DEPTH_LOG2   = 6,
  parameter int IRQ_LEVEL    = 32,
  parameter bit ENABLE_RESET = 1'b1
) (
  input  logic               wb_clk,
  input  logic               wb_rst,
  input  logic               trace_valid,
  input  logic [TRACE_W-1:0] trace_data,
  nanorv32_trace_wb_if.slave wb,
  output logic               irq_o
);
  localparam int          LW         = DEPTH_LOG2 + 1;
  localparam logic [31:0] IRQ_THRESH = 32'(IRQ_LEVEL);

  logic               enable;
  logic               overflow;
  logic [31:0]        dropped;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LW-1:0]      fifo_level;
  logic [TRACE_W-1:0] fifo_head;

  logic        req;
  logic        reg_dbg;
  reg_idx_e    reg_idx;
  logic [31:0] rd_data;
  logic        pend_pop;
  logic        pend_ctrl;
  logic        pend_en;
  logic        pend_clr;
  logic        pop_now;
  logic        ctrl_now;
  logic        clr_now;
  logic        push_req;
  logic        drop_now;

  assign req     = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
  assign reg_idx = reg_idx_e'(wb.wb_adr_i[3:2]);
  assign reg_dbg = ~wb.wb_we_i & (wb.wb_sel_i == 4'b0000);

  // Side effects are decoded at the request edge and applied at the end of the ack cycle
  assign pop_now  = wb.wb_ack_o & pend_pop;
  assign ctrl_now = wb.wb_ack_o & pend_ctrl;
  assign clr_now  = ctrl_now & pend_clr;
  assign push_req = trace_valid & enable & ~clr_now;
  assign drop_now = push_req & fifo_full & ~pop_now;

  nanorv32_sync_fifo #(
    .WIDTH      (TRACE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (wb_clk),
    .rst   (wb_rst),
    .flush (clr_now),
    .push  (push_req),
    .pop   (pop_now),
    .din   (trace_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    rd_data = '0;
    unique case (reg_idx)
      REG_STATUS: begin
        rd_data[ST_EMPTY]             = fifo_empty;
        rd_data[ST_FULL]              = fifo_full;
        rd_data[ST_OVERFLOW]          = overflow;
        rd_data[ST_ENABLE]            = enable;
        rd_data[ST_LEVEL_LSB +: 16]   = 16'(fifo_level);
      end
      REG_CTRL: rd_data[CTRL_EN] = enable;
      REG_HEAD: begin
        if (!fifo_empty) rd_data[3:0] = fifo_head[TRACE_W-1 -: 4];
      end
      REG_DATA: begin
        // sel=0 reads alias the drop counter and never pop
        if (reg_dbg)          rd_data = dropped;
        else if (!fifo_empty) rd_data = fifo_head[31:0];
      end
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
      pend_pop    <= 1'b0;
      pend_ctrl   <= 1'b0;
      pend_en     <= 1'b0;
      pend_clr    <= 1'b0;
      enable      <= ENABLE_RESET;
      overflow    <= 1'b0;
      dropped     <= '0;
      irq_o       <= 1'b0;
    end else begin
      wb.wb_ack_o <= req;
      wb.wb_dat_o <= (req & ~wb.wb_we_i) ? rd_data : '0;
      pend_pop    <= req & ~wb.wb_we_i & (reg_idx == REG_DATA) & ~reg_dbg & ~fifo_empty;
      pend_ctrl   <= req & wb.wb_we_i & (reg_idx == REG_CTRL) & wb.wb_sel_i[0];
      pend_en     <= wb.wb_dat_i[CTRL_EN];
      pend_clr    <= wb.wb_dat_i[CTRL_CLR];

      if (ctrl_now) enable <= pend_en;

      if (clr_now) begin
        overflow <= 1'b0;
        dropped  <= '0;
      end else if (drop_now) begin
        overflow <= 1'b1;
        if (dropped != '1) dropped <= dropped + 32'd1;
      end

      irq_o <= enable & (32'(fifo_level) >= IRQ_THRESH);
    end
  end

endmodule

// File: doc/nanorv32_trace_wb.md
# nanorv32_trace_wb

Wishbone-readable capture buffer for the core's 36-bit instruction trace stream. It sits beside `nanorv32_wrapper_wb`, on the receiving end of `trace_valid`/`trace_data`. Entries are stored in an on-chip FIFO and drained by firmware or a debug master through a classic Wishbone slave port. Overflow is counted rather than stalling the core, and an interrupt is raised when the fill level reaches a threshold.

## Interface
- `DEPTH_LOG2`, 6 — FIFO holds 2^DEPTH_LOG2 entries; legal range 2..15.
- `IRQ_LEVEL`, 32 — `irq_o` asserts when level ≥ this value; legal range 1..2^DEPTH_LOG2.
- `ENABLE_RESET`, 1 — reset value of CTRL.enable.
- `wb_clk  in  1` — single clock.
- `wb_rst  in  1` — reset; synchronous, active-high.
- `trace_valid  in  1` — one trace word offered this cycle.
- `trace_data  in  36` — [35:32] flags (0001 branch, 0010 address, 1000 irq), [31:0] payload.
- `wb_cyc_i  in  1` — Wishbone cycle.
- `wb_stb_i  in  1` — Wishbone strobe.
- `wb_we_i  in  1` — Wishbone write enable.
- `wb_adr_i  in  4` — byte address; [3:2] selects the register, [1:0] ignored.
- `wb_dat_i  in  32` — write data.
- `wb_sel_i  in  4` — byte selects; only sel[0] is honoured for CTRL writes.
- `wb_dat_o  out  32` — read data.
- `wb_ack_o  out  1` — acknowledge.
- `irq_o  out  1` — level interrupt.

## Operation
- Register map (word index):
  - 0 STATUS (RO): [0] empty, [1] full, [2] overflow (sticky), [3] enable, [31:16] level (zero-extended).
  - 1 CTRL (RW): [0] enable, [1] clear. Clear is write-1, self-clearing, and always reads 0.
  - 2 HEAD_FLAGS (RO): [3:0] = flags of the head entry; 0 when empty. Reading does not pop.
  - 3 DATA (RO): payload of the head entry. A read pops the entry if non-empty. Empty reads return 0 with no pop.
- Writes to RO registers are acked and ignored.
- Push rule: `trace_valid & enable`.
  - FIFO not full: the entry is stored.
  - FIFO full, no pop this cycle: the entry is dropped, overflow is set, and DROPPED increments. DROPPED is internal, saturates at 0xFFFF_FFFF, and shares word 3 when `wb_we_i`=0 and sel=4'b0000. It is debug-only and never pops.
  - FIFO full with a pop in the same cycle: the push is accepted, no drop.
- Pushes while enable=0 are ignored and not counted.
- Clear: the FIFO is emptied and overflow and DROPPED are zeroed on the ack cycle of the write. A push in that same cycle is discarded and not counted.
- `irq_o` = enable & (level ≥ IRQ_LEVEL), registered.
- The FIFO uses read/write pointers DEPTH_LOG2+1 bits wide. Full/empty are decided by the MSB mismatch, and the pointers wrap naturally.

## Timing
- Wishbone classic, registered ack.
  - `wb_ack_o` pulses high for exactly one cycle, in the cycle after `wb_cyc_i & wb_stb_i & !wb_ack_o` is sampled.
  - A strobe held across the ack cycle yields a new ack two cycles later (no back-to-back acks).
- `wb_dat_o` is valid in the ack cycle and holds 0 outside it.
- Pop, CTRL update and clear take effect at the clock edge ending the ack cycle. STATUS read in the following transaction reflects them.
- Trace push latency: the entry is visible in level/empty at the next edge. A DATA read started the cycle after the push returns that entry.
- Reset values:
  - `wb_ack_o`=0, `wb_dat_o`=0, `irq_o`=0.
  - FIFO empty, level 0, overflow 0, DROPPED 0.
  - enable=ENABLE_RESET.
- A reset mid-transaction drops the pending ack. The master must restart the access.

## Structure
- Package `nanorv32_trace_pkg` holds:
  - register word indices,
  - STATUS/CTRL bit positions,
  - trace flag encodings (FLAG_BRANCH=4'b0001, FLAG_ADDR=4'b0010, FLAG_IRQ=4'b1000),
  - trace width constant 36.
- Sub-module `nanorv32_sync_fifo` (parameterised WIDTH, DEPTH_LOG2): push/pop, full/empty, level, and a synchronous flush.
- The top level holds the Wishbone decode, ack generation, counters and irq.

## Test plan
- Reset, then read STATUS → 0x0000_0009 (empty, enable). `irq_o`=0.
- Drive 3 trace words {0x2,0x1000_0000}, {0x1,0x1000_0010}, {0x8,0x0000_0010}, then read HEAD_FLAGS/DATA three times → 0x2/0x1000_0000, 0x1/0x1000_0010, 0x8/0x0000_0010. Then STATUS level=0, empty=1.
- DEPTH_LOG2=6: push 70 words without reading → STATUS full=1, overflow=1, level=64. DROPPED=6. The first DATA read returns the 1st word.
- With FIFO full, push and pop in the same cycle → no new drop and level stays 64. Write CTRL=0x3 → level=0, overflow=0, DROPPED=0.
- CTRL=0, then push 5 words → level stays 0 and DROPPED stays 0. DATA read on empty → 0, one ack, no underflow.
- IRQ_LEVEL=32: push 31 words → `irq_o`=0. The 32nd push makes `irq_o`=1 one cycle later. One DATA read clears it. Assert `wb_rst` mid-read → no ack, all reset values restored.
